// File: rtl/oc_uart_rx_monitor.sv
// 8N1 UART receiver with byte FIFO; rxValid rises 1 cycle after the stop-bit sample (+SyncCycles from rxIn).
// Backpressure: bytes wait in the FIFO while rxReady is low; arrivals while full are dropped and flagged.
module oc_uart_rx_fifo #(
  parameter int Depth = 8,
  parameter int Width = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [Width-1:0]           pushData,
  input  logic                       pop,
  output logic [Width-1:0]           headData,
  output logic [$clog2(Depth):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PtrW   = $clog2(Depth);
  localparam int CountW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wrPtr;
  logic [PtrW-1:0]  rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty    = (count == '0);
  assign full     = (count == CountW'(Depth));
  assign doPop    = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + PtrW'(1);
      end
      if (doPop) rdPtr <= rdPtr + PtrW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CountW'(1);
        2'b01:   count <= count - CountW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module oc_uart_rx_monitor #(
  parameter int ClockHz    = 100_000_000,
  parameter int Baud       = 115_200,
  parameter int FifoDepth  = 8,
  parameter int SyncCycles = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         rxIn,
  output logic [7:0]                   rxData,
  output logic                         rxValid,
  input  logic                         rxReady,
  output logic [$clog2(FifoDepth):0]   fifoCount,
  output logic                         frameError,
  output logic                         overflow,
  input  logic                         errorClear,
  output logic                         rxBusy
);
  localparam int Div     = (ClockHz + Baud / 2) / Baud;
  localparam int HalfDiv = Div / 2;
  localparam int CntW    = $clog2(Div) + 1;

  if (Div < 4) begin : gBadDiv
    $error("oc_uart_rx_monitor: bit period Div must be at least 4 clocks");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : gBadDepth
    $error("oc_uart_rx_monitor: FifoDepth must be a power of 2, at least 2");
  end
  if (SyncCycles < 2) begin : gBadSync
    $error("oc_uart_rx_monitor: SyncCycles must be at least 2");
  end

  typedef enum logic [2:0] {stIdle, stStart, stData, stStop, stBreak} stateT;

  stateT                 state, stateNext;
  logic [CntW-1:0]       cnt, cntNext;
  logic [2:0]            bitIdx, bitIdxNext;
  logic [7:0]            shiftReg, shiftNext;
  logic [SyncCycles-1:0] syncQ;
  logic                  rxS;
  logic                  cntZero;
  logic                  push;
  logic                  frameErrSet;
  logic                  overflowSet;
  logic                  popReq;
  logic                  fifoFull;
  logic                  fifoEmpty;

  // Preset to 1 so reset looks like an idle line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) syncQ <= '1;
    else       syncQ <= {syncQ[SyncCycles-2:0], rxIn};
  end
  assign rxS     = syncQ[SyncCycles-1];
  assign cntZero = (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= stIdle;
      cnt      <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      bitIdx   <= bitIdxNext;
      shiftReg <= shiftNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    bitIdxNext  = bitIdx;
    shiftNext   = shiftReg;
    push        = 1'b0;
    frameErrSet = 1'b0;
    case (state)
      stIdle: begin
        if (!rxS) begin
          cntNext   = CntW'(HalfDiv - 1);
          stateNext = stStart;
        end
      end
      stStart: begin
        if (!cntZero) begin
          cntNext = cnt - CntW'(1);
        end else if (rxS) begin
          stateNext = stIdle;
        end else begin
          cntNext    = CntW'(Div - 1);
          bitIdxNext = '0;
          stateNext  = stData;
        end
      end
      stData: begin
        if (!cntZero) begin
          cntNext = cnt - CntW'(1);
        end else begin
          shiftNext = {rxS, shiftReg[7:1]};
          cntNext   = CntW'(Div - 1);
          if (bitIdx == 3'd7) stateNext = stStop;
          else                bitIdxNext = bitIdx + 3'd1;
        end
      end
      stStop: begin
        if (!cntZero) begin
          cntNext = cnt - CntW'(1);
        end else if (rxS) begin
          push      = 1'b1;
          stateNext = stIdle;
        end else begin
          frameErrSet = 1'b1;
          stateNext   = stBreak;
        end
      end
      stBreak: begin
        // A line held low must rise before another frame can start.
        if (rxS) stateNext = stIdle;
      end
      default: stateNext = stIdle;
    endcase
  end

  assign popReq      = rxValid && rxReady;
  assign overflowSet = push && fifoFull && !popReq;

  oc_uart_rx_fifo #(.Depth(FifoDepth), .Width(8)) uFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pushData (shiftReg),
    .pop      (popReq),
    .headData (rxData),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Set wins over a coincident clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frameError <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frameError <= frameErrSet || (frameError && !errorClear);
      overflow   <= overflowSet || (overflow && !errorClear);
    end
  end

  assign rxValid = !fifoEmpty;
  assign rxBusy  = (state != stIdle);
endmodule

// File: tb/tb_oc_uart_rx_monitor.sv
// Directed bench for oc_uart_rx_monitor at Div=16, FifoDepth=4; received bytes are checked against a scoreboard queue.
module tb_oc_uart_rx_monitor;
  localparam int BitCycles = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rxIn;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;
  logic [2:0] fifoCount;
  logic       frameError;
  logic       overflow;
  logic       errorClear;
  logic       rxBusy;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sbQ [$];

  oc_uart_rx_monitor #(
    .ClockHz    (1_843_200),
    .Baud       (115_200),
    .FifoDepth  (4),
    .SyncCycles (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rxIn       (rxIn),
    .rxData     (rxData),
    .rxValid    (rxValid),
    .rxReady    (rxReady),
    .fifoCount  (fifoCount),
    .frameError (frameError),
    .overflow   (overflow),
    .errorClear (errorClear),
    .rxBusy     (rxBusy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopVal, input int stopPeriods);
    rxIn = 1'b0;
    tick(BitCycles);
    for (int i = 0; i < 8; i++) begin
      rxIn = b[i];
      tick(BitCycles);
    end
    rxIn = stopVal;
    tick(BitCycles * stopPeriods);
    rxIn = 1'b1;
  endtask

  // Every accepted byte must match the oldest outstanding expectation.
  always @(negedge clock) begin
    logic [8:0] expB;
    if (!reset && rxValid && rxReady) begin
      expB = (sbQ.size() != 0) ? {1'b0, sbQ.pop_front()} : 9'h100;
      chk("rx_byte", 32'({1'b0, rxData}), 32'(expB));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int busyCnt;

    reset = 1'b1; rxIn = 1'b1; rxReady = 1'b1; errorClear = 1'b0;
    tick(3);
    @(negedge clock);
    chk("reset_rxValid",    32'(rxValid),    0);
    chk("reset_rxData",     32'(rxData),     0);
    chk("reset_fifoCount",  32'(fifoCount),  0);
    chk("reset_frameError", 32'(frameError), 0);
    chk("reset_overflow",   32'(overflow),   0);
    chk("reset_rxBusy",     32'(rxBusy),     0);
    tick(1);
    reset = 1'b0;
    tick(4);

    // Single byte: stop centre at 152 clocks, +2 sync, +1 push register.
    sbQ.push_back(8'hA5);
    fork
      sendByte(8'hA5, 1'b1, 1);
      begin
        n = 0;
        do begin
          @(posedge clock);
          n++;
          @(negedge clock);
        end while (!rxValid && n < 400);
        chk("a5_latency", n, 155);
        chk("a5_data", 32'(rxData), 32'h A5);
        @(negedge clock);
        chk("a5_pulse_width", 32'(rxValid), 0);
      end
    join
    chk("a5_frame_error", 32'(frameError), 0);

    // Glitch: 5 low cycles are gone by the half-bit start sample.
    rxIn = 1'b0;
    busyCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) rxIn = 1'b1;
      @(negedge clock);
      if (rxBusy) busyCnt++;
      tick(1);
    end
    chk("glitch_busy_cycles", busyCnt, 8);
    chk("glitch_no_push", 32'(fifoCount), 0);
    chk("glitch_idle", 32'(rxBusy), 0);

    // Framing error, then recovery.
    sendByte(8'h3C, 1'b0, 3);
    tick(4);
    chk("ferr_set", 32'(frameError), 1);
    chk("ferr_no_push", 32'(fifoCount), 0);
    chk("ferr_break_exit", 32'(rxBusy), 0);
    sbQ.push_back(8'h11);
    sendByte(8'h11, 1'b1, 1);
    tick(2);
    chk("ferr_next_byte_seen", sbQ.size(), 0);
    chk("ferr_sticky", 32'(frameError), 1);
    errorClear = 1'b1;
    tick(1);
    errorClear = 1'b0;
    chk("ferr_cleared", 32'(frameError), 0);

    // Overflow: five bytes into four slots with no consumer.
    rxReady = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) sbQ.push_back(8'(b));
      sendByte(8'(b), 1'b1, 1);
    end
    tick(2);
    chk("ovf_count", 32'(fifoCount), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head", 32'(rxData), 32'h01);
    rxReady = 1'b1;
    tick(6);
    chk("ovf_drained_count", 32'(fifoCount), 0);
    chk("ovf_drained_sb", sbQ.size(), 0);
    errorClear = 1'b1;
    tick(1);
    errorClear = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);

    // Full FIFO with a pop in the same cycle as the fifth push.
    rxReady = 1'b0;
    for (int b = 8'h21; b <= 8'h24; b++) begin
      sbQ.push_back(8'(b));
      sendByte(8'(b), 1'b1, 1);
    end
    tick(2);
    chk("pp_full_before", 32'(fifoCount), 4);
    sbQ.push_back(8'h25);
    fork
      sendByte(8'h25, 1'b1, 1);
      begin
        tick(154);
        rxReady = 1'b1;
        tick(1);
        rxReady = 1'b0;
      end
    join
    chk("pp_count", 32'(fifoCount), 4);
    chk("pp_no_overflow", 32'(overflow), 0);
    chk("pp_head", 32'(rxData), 32'h22);
    rxReady = 1'b1;
    tick(6);
    chk("pp_drained_count", 32'(fifoCount), 0);
    chk("pp_drained_sb", sbQ.size(), 0);

    // Reset in the middle of data bit 4 of 0xFF.
    fork
      sendByte(8'hFF, 1'b1, 1);
      begin
        tick(85);
        chk("mr_busy_before", 32'(rxBusy), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("mr_rxBusy", 32'(rxBusy), 0);
        chk("mr_rxValid", 32'(rxValid), 0);
        chk("mr_rxData", 32'(rxData), 0);
        chk("mr_fifoCount", 32'(fifoCount), 0);
        tick(2);
        reset = 1'b0;
      end
    join
    tick(4);
    chk("mr_no_partial", 32'(fifoCount), 0);
    sbQ.push_back(8'h5A);
    sendByte(8'h5A, 1'b1, 1);
    tick(2);
    chk("mr_5a_seen", sbQ.size(), 0);
    chk("mr_frame_error", 32'(frameError), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
